// File: rtl/out_capture_ram.sv
// out_capture_ram
// ---------------
// Captures the interpolator output stream into on-chip RAM. Each stored sample
// is compared against a golden sample from an external combinational ROM,
// which is indexed by the current write pointer.
//
// Ports
//   clk           rising-edge clock
//   in_rst        asynchronous active-low reset
//   start         one-cycle pulse that arms a capture run (from IDLE or DONE)
//   sample_vld    sample_in is valid this cycle
//   sample_in     DUT output sample
//   exp_addr      golden-ROM index, always equal to the write pointer
//   exp_data      golden sample for exp_addr (same cycle)
//   rd_addr       readback address
//   rd_data       mem[rd_addr], registered, 1-cycle latency, read-first
//   busy          high while skipping or capturing
//   done          high once DEPTH samples have been stored
//   wr_count      samples stored in the current or last run
//   mismatch_cnt  saturating count of compare failures
//   dbg_state     current FSM state, for observation
//
// Handshake: there is no backpressure. A sample is consumed on every rising
// edge where sample_vld is high; when sample_vld is low nothing happens, and
// gaps of any length are allowed.

module out_capture_ram #(
    parameter int OUT    = 10,
    parameter int DEPTH  = 400,
    parameter int ADDR_W = 9,
    parameter int SKIP   = 4,
    parameter int CNT_W  = 16
) (
    input  logic              clk,
    input  logic              in_rst,
    input  logic              start,
    input  logic              sample_vld,
    input  logic [OUT-1:0]    sample_in,
    output logic [ADDR_W-1:0] exp_addr,
    input  logic [OUT-1:0]    exp_data,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [OUT-1:0]    rd_data,
    output logic              busy,
    output logic              done,
    output logic [ADDR_W:0]   wr_count,
    output logic [CNT_W-1:0]  mismatch_cnt,
    output logic [1:0]        dbg_state
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SKIP_S = 2'd1;
    localparam logic [1:0] CAP_S  = 2'd2;
    localparam logic [1:0] DONE_S = 2'd3;

    // With no samples to skip, a run goes straight to capture.
    localparam logic [1:0] ARM_ST = (SKIP == 0) ? CAP_S : SKIP_S;

    localparam int                SKIP_W    = (SKIP > 1) ? $clog2(SKIP) : 1;
    localparam logic [SKIP_W-1:0] SKIP_LAST = SKIP_W'((SKIP > 0) ? SKIP - 1 : 0);
    localparam logic [SKIP_W-1:0] SKIP_ONE  = SKIP_W'(1);
    localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
    localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);
    localparam logic [ADDR_W:0]   WC_ONE    = (ADDR_W + 1)'(1);
    localparam logic [CNT_W-1:0]  CNT_ONE   = CNT_W'(1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = '1;

    logic [1:0]        state_q, state_d;
    logic [SKIP_W-1:0] skip_cnt_q, skip_cnt_d;
    logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [ADDR_W:0]   wr_count_q, wr_count_d;
    logic [CNT_W-1:0]  mismatch_q, mismatch_d;
    logic [OUT-1:0]    rd_data_q;
    logic              wr_en;

    logic [OUT-1:0]    mem [DEPTH];

    assign wr_en = (state_q == CAP_S) && sample_vld;

    always_comb begin
        state_d    = state_q;
        skip_cnt_d = skip_cnt_q;
        wr_ptr_d   = wr_ptr_q;
        wr_count_d = wr_count_q;
        mismatch_d = mismatch_q;
        case (state_q)
            // start is honoured only when not busy; a run in progress is never restarted.
            IDLE, DONE_S: begin
                if (start) begin
                    state_d    = ARM_ST;
                    skip_cnt_d = '0;
                    wr_ptr_d   = '0;
                    wr_count_d = '0;
                    mismatch_d = '0;
                end
            end
            SKIP_S: begin
                if (sample_vld) begin
                    skip_cnt_d = skip_cnt_q + SKIP_ONE;
                    if (skip_cnt_q == SKIP_LAST) begin
                        state_d = CAP_S;
                    end
                end
            end
            CAP_S: begin
                if (sample_vld) begin
                    wr_count_d = wr_count_q + WC_ONE;
                    if ((sample_in != exp_data) && (mismatch_q != CNT_MAX)) begin
                        mismatch_d = mismatch_q + CNT_ONE;
                    end
                    // The pointer parks on the last address so exp_addr does not wrap.
                    if (wr_ptr_q == LAST_ADDR) begin
                        state_d = DONE_S;
                    end else begin
                        wr_ptr_d = wr_ptr_q + ADDR_ONE;
                    end
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge in_rst) begin
        if (!in_rst) begin
            state_q    <= IDLE;
            skip_cnt_q <= '0;
            wr_ptr_q   <= '0;
            wr_count_q <= '0;
            mismatch_q <= '0;
            rd_data_q  <= '0;
        end else begin
            state_q    <= state_d;
            skip_cnt_q <= skip_cnt_d;
            wr_ptr_q   <= wr_ptr_d;
            wr_count_q <= wr_count_d;
            mismatch_q <= mismatch_d;
            rd_data_q  <= mem[rd_addr];
        end
    end

    // RAM array has no reset. The read in the block above uses the pre-edge
    // contents, so a same-address read/write returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr_q] <= sample_in;
        end
    end

    assign exp_addr     = wr_ptr_q;
    assign rd_data      = rd_data_q;
    assign busy         = (state_q == SKIP_S) || (state_q == CAP_S);
    assign done         = (state_q == DONE_S);
    assign wr_count     = wr_count_q;
    assign mismatch_cnt = mismatch_q;
    assign dbg_state    = state_q;

endmodule
